bus_rr_arbiter: RTL and testbench
=================================

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 Parameter NrHosts, default 2: number of requesting hosts (2..8).
REQ-002 Parameter DataWidth, default 32: data width; byte-enable width is DataWidth/8.
REQ-003 Parameter AddressWidth, default 32: address width.
REQ-004 Parameter MaxOutstanding, default 2: accepted requests awaiting response (1..8).
REQ-005 clk_i  in  1  single clock; all state on rising edge.
REQ-006 rst_ni  in  1  asynchronous, active-low reset.
REQ-007 host_req_i / host_we_i  in  1 [NrHosts]  per-host request / write flag.
REQ-008 host_addr_i  in  AddressWidth [NrHosts]  per-host address.
REQ-009 host_be_i / host_wdata_i  in  DataWidth/8 / DataWidth [NrHosts]  per-host byte enables / write data.
REQ-010 host_gnt_o / host_rvalid_o / host_err_o  out  1 [NrHosts]  per-host grant / response valid / response error.
REQ-011 host_rdata_o  out  DataWidth [NrHosts]  per-host read data.
REQ-012 dev_req_o / dev_we_o  out  1  device request / write flag.
REQ-013 dev_addr_o / dev_be_o / dev_wdata_o  out  AddressWidth / DataWidth/8 / DataWidth  muxed request fields.
REQ-014 dev_gnt_i / dev_rvalid_i / dev_err_i  in  1  device grant / response valid / error.
REQ-015 dev_rdata_i  in  DataWidth  device read data.
REQ-016 spurious_o  out  1  one-cycle pulse on a device response with no outstanding request.

Function
REQ-017 Selection is round-robin: the first requesting host searching upward from last_grant+1 modulo NrHosts.
REQ-018 Lock: dev_req_o high and dev_gnt_i low sets lock; selection then holds that host until its handshake, ignoring other hosts.
REQ-019 dev_req_o = selected host requesting AND outstanding count < MaxOutstanding; request fields are the selected host's, combinational, zero added latency.
REQ-020 host_gnt_o[sel] = dev_req_o AND dev_gnt_i; every other host_gnt_o bit is 0.
REQ-021 Handshake (dev_req_o AND dev_gnt_i): last_grant <= sel, lock cleared, sel pushed into the ID FIFO, count +1.
REQ-022 Without a handshake, last_grant is unchanged.
REQ-023 ID FIFO: depth MaxOutstanding, in-order, pointers wrap modulo MaxOutstanding.
REQ-024 dev_rvalid_i with count>0: host_rvalid_o[head]=1 in the same cycle, head popped, count -1.
REQ-025 host_rdata_o[i] = dev_rdata_i for all i; host_err_o[i] = dev_err_i AND host_rvalid_o[i].
REQ-026 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-027 Full (count==MaxOutstanding): dev_req_o=0 and no grant, even if a pop occurs the same cycle; issue resumes the next cycle.
REQ-028 dev_rvalid_i with count==0: no host_rvalid_o, no state change, spurious_o=1 that cycle.
REQ-029 A host deasserting host_req_i while locked and ungranted is a protocol violation; the arbiter clears lock and reselects next cycle.
REQ-030 dev_we_o/be/wdata carry the selected host's values even when dev_req_o=0; no X-masking.

Reset
REQ-031 Reset values: last_grant=NrHosts-1 (host 0 wins first), lock=0, count=0, FIFO pointers=0.
REQ-032 Under reset: host_gnt_o=0, host_rvalid_o=0, host_err_o=0, spurious_o=0.
REQ-033 Reset mid-transaction discards outstanding IDs; responses arriving after reset release raise spurious_o.

Verification
REQ-034 Hosts 0,1 request continuously, dev_gnt_i=1, dev_rvalid_i one cycle after each grant -> grants alternate 0,1,0,1; each rvalid reaches the granted host.
REQ-035 Host 1 requests, dev_gnt_i held 0 for 3 cycles, host 0 requests in cycle 1 -> dev_addr_o stays host 1's address; grant to host 1 in cycle 3; host 0 granted next.
REQ-036 MaxOutstanding=2, two grants, no response -> dev_req_o=0; rvalid in cycle N -> dev_req_o reasserts in cycle N+1, not N.
REQ-037 Grants to hosts 0,1,0 then three responses with dev_err_i on the 2nd -> rvalid order 0,1,0; host_err_o[1]=1 only on the 2nd response.
REQ-038 dev_rvalid_i with count=0 -> spurious_o pulses 1 cycle; all host_rvalid_o remain 0.
REQ-039 rst_ni asserted with 1 outstanding, then released -> count=0; host 0 wins first arbitration; stale rvalid raises spurious_o.

Source files
------------

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter that multiplexes NrHosts request ports onto one device port.
// Routes in-order device responses back to the requesting host through an ID FIFO.
module bus_rr_arbiter #(
  parameter int unsigned NrHosts        = 2,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [NrHosts-1:0]                       host_req_i,
  input  logic [NrHosts-1:0]                       host_we_i,
  input  logic [NrHosts-1:0][AddressWidth-1:0]     host_addr_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]      host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]        host_wdata_i,
  output logic [NrHosts-1:0]                       host_gnt_o,
  output logic [NrHosts-1:0]                       host_rvalid_o,
  output logic [NrHosts-1:0]                       host_err_o,
  output logic [NrHosts-1:0][DataWidth-1:0]        host_rdata_o,
  output logic                                     dev_req_o,
  output logic                                     dev_we_o,
  output logic [AddressWidth-1:0]                  dev_addr_o,
  output logic [DataWidth/8-1:0]                   dev_be_o,
  output logic [DataWidth-1:0]                     dev_wdata_o,
  input  logic                                     dev_gnt_i,
  input  logic                                     dev_rvalid_i,
  input  logic                                     dev_err_i,
  input  logic [DataWidth-1:0]                     dev_rdata_i,
  output logic                                     spurious_o
);

  localparam int unsigned HostW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);

  localparam logic [HostW-1:0] LastHost = HostW'(NrHosts - 1);
  localparam logic [PtrW-1:0]  LastSlot = PtrW'(MaxOutstanding - 1);
  localparam logic [CntW-1:0]  MaxCnt   = CntW'(MaxOutstanding);

  logic [HostW-1:0] last_grant_q;
  logic             lock_q;
  logic [HostW-1:0] lock_host_q;
  logic [HostW-1:0] fifo_q [MaxOutstanding];
  logic [PtrW-1:0]  head_q;
  logic [PtrW-1:0]  tail_q;
  logic [CntW-1:0]  count_q;

  logic [HostW-1:0] rr_sel;
  logic             rr_found;
  logic [HostW-1:0] sel;
  logic             not_full;
  logic             handshake;
  logic             pop;

  // First requesting host searching upward from last_grant+1, wrapping.
  always_comb begin
    int unsigned idx;
    rr_sel   = (last_grant_q == LastHost) ? '0 : last_grant_q + HostW'(1);
    rr_found = 1'b0;
    idx      = 0;
    for (int unsigned i = 1; i <= NrHosts; i++) begin
      idx = 32'(last_grant_q) + i;
      if (idx >= NrHosts) idx = idx - NrHosts;
      if (!rr_found && host_req_i[HostW'(idx)]) begin
        rr_sel   = HostW'(idx);
        rr_found = 1'b1;
      end
    end
  end

  assign sel       = lock_q ? lock_host_q : rr_sel;
  assign not_full  = (count_q != MaxCnt);
  assign dev_req_o = rst_ni & host_req_i[sel] & not_full;
  assign dev_we_o    = host_we_i[sel];
  assign dev_addr_o  = host_addr_i[sel];
  assign dev_be_o    = host_be_i[sel];
  assign dev_wdata_o = host_wdata_i[sel];

  assign handshake  = dev_req_o & dev_gnt_i;
  assign pop        = rst_ni & dev_rvalid_i & (count_q != '0);
  assign spurious_o = rst_ni & dev_rvalid_i & (count_q == '0);

  // Per-host grant, response steering and broadcast read data.
  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    if (handshake) host_gnt_o[sel] = 1'b1;
    if (pop)       host_rvalid_o[fifo_q[head_q]] = 1'b1;
    host_err_o = host_rvalid_o & {NrHosts{dev_err_i}};
    for (int unsigned i = 0; i < NrHosts; i++) begin
      host_rdata_o[i] = dev_rdata_i;
    end
  end

  // Arbitration state: last winner and lock onto a stalled request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= LastHost;
      lock_q       <= 1'b0;
      lock_host_q  <= '0;
    end else if (handshake) begin
      last_grant_q <= sel;
      lock_q       <= 1'b0;
    end else if (dev_req_o) begin
      lock_q      <= 1'b1;
      lock_host_q <= sel;
    end else if (lock_q && !host_req_i[lock_host_q]) begin
      lock_q <= 1'b0;
    end
  end

  // In-order ID FIFO of granted hosts awaiting a response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < MaxOutstanding; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (handshake) begin
        fifo_q[tail_q] <= sel;
        tail_q         <= (tail_q == LastSlot) ? '0 : tail_q + PtrW'(1);
      end
      if (pop) begin
        head_q <= (head_q == LastSlot) ? '0 : head_q + PtrW'(1);
      end
      case ({handshake, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed scenarios with hand-derived expectations,
// then randomized traffic checked against a queue-based reference model.
module tb_bus_rr_arbiter;

  localparam int NH = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MO = 2;
  localparam int BW = DW / 8;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [NH-1:0]          host_req_i;
  logic [NH-1:0]          host_we_i;
  logic [NH-1:0][AW-1:0]  host_addr_i;
  logic [NH-1:0][BW-1:0]  host_be_i;
  logic [NH-1:0][DW-1:0]  host_wdata_i;
  logic [NH-1:0]          host_gnt_o;
  logic [NH-1:0]          host_rvalid_o;
  logic [NH-1:0]          host_err_o;
  logic [NH-1:0][DW-1:0]  host_rdata_o;
  logic                   dev_req_o;
  logic                   dev_we_o;
  logic [AW-1:0]          dev_addr_o;
  logic [BW-1:0]          dev_be_o;
  logic [DW-1:0]          dev_wdata_o;
  logic                   dev_gnt_i;
  logic                   dev_rvalid_i;
  logic                   dev_err_i;
  logic [DW-1:0]          dev_rdata_i;
  logic                   spurious_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  bus_rr_arbiter #(
    .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o), .host_err_o(host_err_o),
    .host_rdata_o(host_rdata_o),
    .dev_req_o(dev_req_o), .dev_we_o(dev_we_o), .dev_addr_o(dev_addr_o),
    .dev_be_o(dev_be_o), .dev_wdata_o(dev_wdata_o),
    .dev_gnt_i(dev_gnt_i), .dev_rvalid_i(dev_rvalid_i), .dev_err_i(dev_err_i),
    .dev_rdata_i(dev_rdata_i), .spurious_o(spurious_o)
  );

  // Reference model: outstanding hosts as a queue, lock as the held host or -1.
  int m_last;
  int m_lock;
  int m_q[$];
  int m_sel;
  logic m_hs, m_pop;
  logic          e_req, e_we, e_spur;
  logic [AW-1:0] e_addr;
  logic [BW-1:0] e_be;
  logic [DW-1:0] e_wdata;
  logic [NH-1:0] e_gnt, e_rvalid, e_err;

  function automatic void model_reset();
    m_last = NH - 1;
    m_lock = -1;
    m_q.delete();
  endfunction

  function automatic void model_eval();
    if (m_lock >= 0) m_sel = m_lock;
    else begin
      m_sel = (m_last + 1) % NH;
      for (int k = 1; k <= NH; k++) begin
        if (host_req_i[(m_last + k) % NH]) begin
          m_sel = (m_last + k) % NH;
          break;
        end
      end
    end
    e_req   = rst_ni && host_req_i[m_sel] && (m_q.size() < MO);
    e_we    = host_we_i[m_sel];
    e_addr  = host_addr_i[m_sel];
    e_be    = host_be_i[m_sel];
    e_wdata = host_wdata_i[m_sel];
    m_hs    = e_req && dev_gnt_i;
    e_gnt   = m_hs ? (NH'(1) << m_sel) : '0;
    m_pop   = rst_ni && dev_rvalid_i && (m_q.size() > 0);
    e_rvalid = m_pop ? (NH'(1) << m_q[0]) : '0;
    e_err   = dev_err_i ? e_rvalid : '0;
    e_spur  = rst_ni && dev_rvalid_i && (m_q.size() == 0);
  endfunction

  function automatic void model_commit();
    if (!rst_ni) begin
      model_reset();
      return;
    end
    if (m_pop) void'(m_q.pop_front());
    if (m_hs) begin
      m_q.push_back(m_sel);
      m_last = m_sel;
      m_lock = -1;
    end else if (e_req) begin
      m_lock = m_sel;
    end else if (m_lock >= 0 && !host_req_i[m_lock]) begin
      m_lock = -1;
    end
  endfunction

  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle();
    host_req_i   = '0;
    dev_gnt_i    = 1'b0;
    dev_rvalid_i = 1'b0;
    dev_err_i    = 1'b0;
  endtask

  task automatic new_payload();
    for (int h = 0; h < NH; h++) begin
      host_addr_i[h]  = $urandom;
      host_wdata_i[h] = $urandom;
      host_be_i[h]    = BW'($urandom);
      host_we_i[h]    = 1'($urandom);
    end
    dev_rdata_i = $urandom;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    host_req_i = '1; dev_gnt_i = 1'b1; dev_rvalid_i = 1'b1; dev_err_i = 1'b1;
    #1;
    vectors++; if (host_gnt_o !== '0) begin miscompares++; $display("FAIL rst_gnt got=%b exp=00", host_gnt_o); end
    vectors++; if (host_rvalid_o !== '0) begin miscompares++; $display("FAIL rst_rvalid got=%b exp=00", host_rvalid_o); end
    vectors++; if (host_err_o !== '0) begin miscompares++; $display("FAIL rst_err got=%b exp=00", host_err_o); end
    vectors++; if (spurious_o !== 1'b0) begin miscompares++; $display("FAIL rst_spur got=%b exp=0", spurious_o); end
    cyc();
    idle();
    rst_ni = 1'b1;
    cyc();
  endtask

  // Two hosts always requesting, device always granting, response one cycle later.
  task automatic test_alternate();
    int g;
    logic [NH-1:0] e;
    new_payload();
    for (int k = 0; k < 6; k++) begin
      host_req_i = 2'b11; dev_gnt_i = 1'b1; dev_rvalid_i = (k > 0);
      #1;
      g = k % 2;
      e = NH'(1) << g;
      vectors++; if (host_gnt_o !== e) begin miscompares++; $display("FAIL alt_gnt k=%0d got=%b exp=%b", k, host_gnt_o, e); end
      vectors++; if (dev_addr_o !== host_addr_i[g]) begin miscompares++; $display("FAIL alt_addr k=%0d got=%h exp=%h", k, dev_addr_o, host_addr_i[g]); end
      if (k > 0) begin
        e = NH'(1) << ((k - 1) % 2);
        vectors++; if (host_rvalid_o !== e) begin miscompares++; $display("FAIL alt_rvalid k=%0d got=%b exp=%b", k, host_rvalid_o, e); end
      end
      cyc();
    end
    idle(); dev_rvalid_i = 1'b1;
    #1;
    vectors++; if (host_rvalid_o !== 2'b10) begin miscompares++; $display("FAIL alt_drain got=%b exp=10", host_rvalid_o); end
    cyc();
    idle();
  endtask

  // Stalled request from host 1 must hold the device port until granted.
  task automatic test_lock();
    logic [1:0] req_t [5] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b01};
    logic       gnt_t [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] egnt_t [5] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01};
    int         host_t [5] = '{1, 1, 1, 1, 0};
    new_payload();
    for (int k = 0; k < 5; k++) begin
      host_req_i = req_t[k]; dev_gnt_i = gnt_t[k];
      #1;
      vectors++; if (dev_req_o !== 1'b1) begin miscompares++; $display("FAIL lock_req k=%0d got=%b exp=1", k, dev_req_o); end
      vectors++; if (dev_addr_o !== host_addr_i[host_t[k]]) begin miscompares++; $display("FAIL lock_addr k=%0d got=%h exp=%h", k, dev_addr_o, host_addr_i[host_t[k]]); end
      vectors++; if (host_gnt_o !== egnt_t[k]) begin miscompares++; $display("FAIL lock_gnt k=%0d got=%b exp=%b", k, host_gnt_o, egnt_t[k]); end
      cyc();
    end
    idle(); dev_rvalid_i = 1'b1;
    #1;
    vectors++; if (host_rvalid_o !== 2'b10) begin miscompares++; $display("FAIL lock_drain0 got=%b exp=10", host_rvalid_o); end
    cyc();
    #1;
    vectors++; if (host_rvalid_o !== 2'b01) begin miscompares++; $display("FAIL lock_drain1 got=%b exp=01", host_rvalid_o); end
    cyc();
    idle();
  endtask

  // Outstanding limit: no issue while full, resumes the cycle after a pop.
  task automatic test_full();
    logic       rv_t   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       ereq_t [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0] egnt_t [6] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    logic [1:0] erv_t  [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
    for (int k = 0; k < 6; k++) begin
      host_req_i = 2'b11; dev_gnt_i = 1'b1; dev_rvalid_i = rv_t[k];
      #1;
      vectors++; if (dev_req_o !== ereq_t[k]) begin miscompares++; $display("FAIL full_req k=%0d got=%b exp=%b", k, dev_req_o, ereq_t[k]); end
      vectors++; if (host_gnt_o !== egnt_t[k]) begin miscompares++; $display("FAIL full_gnt k=%0d got=%b exp=%b", k, host_gnt_o, egnt_t[k]); end
      vectors++; if (host_rvalid_o !== erv_t[k]) begin miscompares++; $display("FAIL full_rvalid k=%0d got=%b exp=%b", k, host_rvalid_o, erv_t[k]); end
      cyc();
    end
    idle(); dev_rvalid_i = 1'b1;
    #1;
    vectors++; if (host_rvalid_o !== 2'b01) begin miscompares++; $display("FAIL full_drain0 got=%b exp=01", host_rvalid_o); end
    cyc();
    #1;
    vectors++; if (host_rvalid_o !== 2'b10) begin miscompares++; $display("FAIL full_drain1 got=%b exp=10", host_rvalid_o); end
    cyc();
    idle();
  endtask

  // Grants 0,1,0 and in-order responses with an error on the second.
  task automatic test_err_order();
    logic [1:0] req_t  [6] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00};
    logic       gnt_t  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       rv_t   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       er_t   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0] egnt_t [6] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
    logic [1:0] erv_t  [6] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01};
    logic [1:0] eer_t  [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
    logic [NH-1:0][DW-1:0] erd;
    for (int k = 0; k < 6; k++) begin
      host_req_i = req_t[k]; dev_gnt_i = gnt_t[k]; dev_rvalid_i = rv_t[k]; dev_err_i = er_t[k];
      dev_rdata_i = $urandom;
      #1;
      erd = {NH{dev_rdata_i}};
      vectors++; if (host_gnt_o !== egnt_t[k]) begin miscompares++; $display("FAIL err_gnt k=%0d got=%b exp=%b", k, host_gnt_o, egnt_t[k]); end
      vectors++; if (host_rvalid_o !== erv_t[k]) begin miscompares++; $display("FAIL err_rvalid k=%0d got=%b exp=%b", k, host_rvalid_o, erv_t[k]); end
      vectors++; if (host_err_o !== eer_t[k]) begin miscompares++; $display("FAIL err_err k=%0d got=%b exp=%b", k, host_err_o, eer_t[k]); end
      vectors++; if (host_rdata_o !== erd) begin miscompares++; $display("FAIL err_rdata k=%0d got=%h exp=%h", k, host_rdata_o, erd); end
      cyc();
    end
    idle();
  endtask

  task automatic test_spurious();
    idle(); dev_rvalid_i = 1'b1;
    #1;
    vectors++; if (spurious_o !== 1'b1) begin miscompares++; $display("FAIL spur_pulse got=%b exp=1", spurious_o); end
    vectors++; if (host_rvalid_o !== '0) begin miscompares++; $display("FAIL spur_rvalid got=%b exp=00", host_rvalid_o); end
    cyc();
    dev_rvalid_i = 1'b0;
    #1;
    vectors++; if (spurious_o !== 1'b0) begin miscompares++; $display("FAIL spur_clear got=%b exp=0", spurious_o); end
    cyc();
  endtask

  // Reset with one outstanding: state cleared, host 0 first, stale response is spurious.
  task automatic test_reset_mid();
    host_req_i = 2'b10; dev_gnt_i = 1'b1;
    #1;
    vectors++; if (host_gnt_o !== 2'b10) begin miscompares++; $display("FAIL rmid_gnt got=%b exp=10", host_gnt_o); end
    cyc();
    idle(); rst_ni = 1'b0;
    cyc();
    rst_ni = 1'b1;
    host_req_i = 2'b11; dev_gnt_i = 1'b1; dev_rvalid_i = 1'b1;
    #1;
    vectors++; if (host_gnt_o !== 2'b01) begin miscompares++; $display("FAIL rmid_first got=%b exp=01", host_gnt_o); end
    vectors++; if (spurious_o !== 1'b1) begin miscompares++; $display("FAIL rmid_spur got=%b exp=1", spurious_o); end
    vectors++; if (host_rvalid_o !== '0) begin miscompares++; $display("FAIL rmid_rvalid got=%b exp=00", host_rvalid_o); end
    cyc();
    idle(); dev_rvalid_i = 1'b1;
    #1;
    vectors++; if (host_rvalid_o !== 2'b01) begin miscompares++; $display("FAIL rmid_drain got=%b exp=01", host_rvalid_o); end
    cyc();
    idle();
  endtask

  // Random traffic, every output checked against the reference model.
  task automatic test_random();
    idle(); rst_ni = 1'b0;
    cyc();
    rst_ni = 1'b1;
    model_reset();
    for (int k = 0; k < 800; k++) begin
      new_payload();
      for (int h = 0; h < NH; h++) host_req_i[h] = ($urandom_range(0, 9) < 7);
      dev_gnt_i    = ($urandom_range(0, 9) < 6);
      dev_rvalid_i = ($urandom_range(0, 9) < 4);
      dev_err_i    = 1'($urandom);
      #1;
      model_eval();
      vectors++; if (dev_req_o !== e_req) begin miscompares++; $display("FAIL rnd_req k=%0d got=%b exp=%b", k, dev_req_o, e_req); end
      vectors++; if ({dev_we_o, dev_addr_o, dev_be_o, dev_wdata_o} !== {e_we, e_addr, e_be, e_wdata}) begin
        miscompares++; $display("FAIL rnd_fields k=%0d got=%b/%h/%h/%h exp=%b/%h/%h/%h", k, dev_we_o, dev_addr_o, dev_be_o, dev_wdata_o, e_we, e_addr, e_be, e_wdata);
      end
      vectors++; if (host_gnt_o !== e_gnt) begin miscompares++; $display("FAIL rnd_gnt k=%0d got=%b exp=%b", k, host_gnt_o, e_gnt); end
      vectors++; if (host_rvalid_o !== e_rvalid) begin miscompares++; $display("FAIL rnd_rvalid k=%0d got=%b exp=%b", k, host_rvalid_o, e_rvalid); end
      vectors++; if (host_err_o !== e_err) begin miscompares++; $display("FAIL rnd_err k=%0d got=%b exp=%b", k, host_err_o, e_err); end
      vectors++; if (spurious_o !== e_spur) begin miscompares++; $display("FAIL rnd_spur k=%0d got=%b exp=%b", k, spurious_o, e_spur); end
      cyc();
      model_commit();
    end
    idle();
  endtask

  initial begin
    rst_ni = 1'b0;
    idle();
    new_payload();
    @(negedge clk_i);
    test_reset();
    test_alternate();
    test_lock();
    test_full();
    test_err_order();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
